// File: rtl/pdm_mic_ctrl_if.sv
// Stereo frame stream from the PDM capture sequencer to its consumer.
// valid/ready: a frame transfers on each clk edge where frame_valid=1 and frame_ready=1; while
// frame_valid=1 and frame_ready=0 frame_data holds; frame_valid may drop unaccepted only when capture is disabled.
interface pdm_mic_ctrl_if;
    logic [31:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;

    modport master (output frame_data, output frame_valid, input frame_ready);
    modport slave  (input frame_data, input frame_valid, output frame_ready);
endinterface

// File: rtl/pdm_mic_ctrl.sv
// Stereo PDM microphone sequencer: PDM clock and filter strobes, power-up warmup,
// and a 2-entry stereo frame buffer with sticky overrun detection.
module pdm_mic_ctrl #(
    parameter int DIV_PDM = 20,
    parameter int DECIM   = 128,
    parameter int WARMUP  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    output logic           clk_pdm,
    output logic           stb_left,
    output logic           stb_right,
    output logic           stb_pcm,
    input  logic [15:0]    pcm_left,
    input  logic [15:0]    pcm_right,
    pdm_mic_ctrl_if.master frm,
    output logic           running,
    output logic           overrun,
    input  logic           clr_overrun,
    output logic [1:0]     state_dbg
);
    localparam int CW = $clog2(DIV_PDM);
    localparam int DW = $clog2(DECIM);
    localparam int WW = $clog2(WARMUP + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV_PDM - 1);
    localparam logic [CW-1:0] CNT_LEFT  = CW'(DIV_PDM / 2 - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(DIV_PDM / 2);
    localparam logic [DW-1:0] DEC_LAST  = DW'(DECIM - 1);
    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP - 1);

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_WARMUP = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [DW-1:0] dec;
    logic [WW-1:0] warm;
    logic          go;
    logic          cap1, cap2;
    logic [1:0]    count;
    logic [31:0]   mem0, mem1;
    logic [31:0]   din;
    logic          pop, push, drop;

    // go is low both while OFF and on the cycle that is about to leave for OFF.
    assign go        = enable && (state != S_OFF);
    assign state_dbg = state;
    assign stb_left  = (state != S_OFF) && (cnt == CNT_LEFT);
    assign stb_right = (state != S_OFF) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_OFF;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_OFF:    if (enable) state_next = S_WARMUP;
            S_WARMUP: begin
                if (!enable)                            state_next = S_OFF;
                else if (stb_pcm && warm == WARM_LAST)  state_next = S_RUN;
            end
            S_RUN:    if (!enable) state_next = S_OFF;
            default:  state_next = S_OFF;
        endcase
    end

    always_comb begin
        cnt_next = '0;
        if (go) cnt_next = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end

    // clk_pdm is registered from the next phase so it lines up exactly with cnt.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            dec     <= '0;
            warm    <= '0;
            clk_pdm <= 1'b0;
            stb_pcm <= 1'b0;
            cap1    <= 1'b0;
            cap2    <= 1'b0;
            running <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            clk_pdm <= (cnt_next >= CNT_HALF);
            stb_pcm <= go && stb_right && (dec == DEC_LAST);
            running <= (state_next == S_RUN);
            cap1    <= go && stb_pcm && (state == S_RUN);
            cap2    <= go && cap1;
            if (!go) begin
                dec  <= '0;
                warm <= '0;
            end else begin
                if (stb_right)                    dec  <= (dec == DEC_LAST) ? '0 : dec + DW'(1);
                if (stb_pcm && state == S_WARMUP) warm <= warm + WW'(1);
            end
        end
    end

    // Filter outputs settle two cycles after stb_pcm; cap2 marks that sampling cycle.
    assign din  = {pcm_left, pcm_right};
    assign pop  = (count != 2'd0) && frm.frame_ready;
    assign push = cap2 && enable;
    assign drop = push && (count == 2'd2) && !pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count   <= '0;
            mem0    <= '0;
            mem1    <= '0;
            overrun <= 1'b0;
        end else begin
            if (!enable) begin
                count <= '0;
            end else if (pop && push) begin
                if (count == 2'd2) begin
                    mem0 <= mem1;
                    mem1 <= din;
                end else begin
                    mem0 <= din;
                end
            end else if (pop) begin
                mem0  <= mem1;
                count <= count - 2'd1;
            end else if (push && !drop) begin
                if (count == 2'd0) mem0 <= din;
                else               mem1 <= din;
                count <= count + 2'd1;
            end
            if (drop)             overrun <= 1'b1;
            else if (clr_overrun) overrun <= 1'b0;
        end
    end

    assign frm.frame_valid = (count != 2'd0);
    assign frm.frame_data  = (count != 2'd0) ? mem0 : 32'd0;
endmodule

// File: tb/tb_pdm_mic_ctrl.sv
// Bench for pdm_mic_ctrl: startup vector table, directed corner sequences, randomized
// traffic, and a per-cycle reference model built from period arithmetic and a frame queue.
module tb_pdm_mic_ctrl;
    localparam int DIV_PDM = 20;
    localparam int DECIM   = 16;
    localparam int WARMUP  = 16;
    localparam int P       = DIV_PDM * DECIM;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        clr_overrun = 1'b0;
    logic [15:0] pcm_left = '0;
    logic [15:0] pcm_right = '0;
    logic        clk_pdm, stb_left, stb_right, stb_pcm, running, overrun;
    logic [1:0]  state_dbg;

    pdm_mic_ctrl_if frm();

    int n_checks = 0;
    int n_fails  = 0;
    bit mon_en   = 1'b0;

    // Reference model state: active flag, cycles since enable, frame queue, overrun flag.
    bit          m_on  = 1'b0;
    int          m_t   = 0;
    bit          m_ovr = 1'b0;
    logic [31:0] exp_q[$];

    typedef struct {
        int         t;
        logic [3:0] exp;
    } vec_t;
    vec_t vecs [12];

    pdm_mic_ctrl #(.DIV_PDM(DIV_PDM), .DECIM(DECIM), .WARMUP(WARMUP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .clk_pdm     (clk_pdm),
        .stb_left    (stb_left),
        .stb_right   (stb_right),
        .stb_pcm     (stb_pcm),
        .pcm_left    (pcm_left),
        .pcm_right   (pcm_right),
        .frm         (frm),
        .running     (running),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
        .state_dbg   (state_dbg)
    );

    // Clock and watchdog
    always #5 clk = ~clk;
    initial frm.frame_ready = 1'b0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time %0t reached, required end before 1000000", $time);
        $fatal(1, "bench timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ctrl_vec();
        return {clk_pdm, stb_left, stb_right, stb_pcm, running, frm.frame_valid, overrun};
    endfunction

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    // Advances at least one cycle, stopping on the next stb_pcm or after a 2-period budget.
    task automatic wait_pcm(input string name, output int waited);
        waited = 0;
        do begin
            tick(1);
            waited++;
        end while (stb_pcm !== 1'b1 && waited < 2 * P);
        check(name, {31'd0, stb_pcm}, 32'd1);
    endtask

    // Reference model: compare this cycle, then apply this cycle's inputs at the coming edge.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [6:0]  e;
            logic [31:0] ed;
            bit          pop, push, drop;
            int          ph;
            ph = m_t % DIV_PDM;
            e  = '0;
            if (m_on) begin
                e[6] = (ph >= DIV_PDM / 2);
                e[5] = (ph == DIV_PDM / 2 - 1);
                e[4] = (ph == DIV_PDM - 1);
                e[3] = (m_t > 0) && (m_t % P == 0);
                e[2] = (m_t > WARMUP * P);
            end
            e[1] = (exp_q.size() != 0);
            e[0] = m_ovr;
            ed   = (exp_q.size() != 0) ? exp_q[0] : 32'd0;
            check("model_ctrl", {25'd0, ctrl_vec()}, {25'd0, e});
            check("model_data", frm.frame_data, ed);

            if (!rst_n) begin
                m_on  = 1'b0;
                m_t   = 0;
                m_ovr = 1'b0;
                exp_q.delete();
            end else begin
                pop  = (exp_q.size() != 0) && frm.frame_ready;
                push = m_on && (m_t - 2 >= (WARMUP + 1) * P) && ((m_t - 2) % P == 0);
                drop = 1'b0;
                if (!enable) begin
                    m_on = 1'b0;
                    m_t  = 0;
                    exp_q.delete();
                end else begin
                    if (m_on) m_t++;
                    else begin
                        m_on = 1'b1;
                        m_t  = 0;
                    end
                    if (pop) void'(exp_q.pop_front());
                    if (push) begin
                        if (exp_q.size() < 2) exp_q.push_back({pcm_left, pcm_right});
                        else                  drop = 1'b1;
                    end
                end
                if (drop)             m_ovr = 1'b1;
                else if (clr_overrun) m_ovr = 1'b0;
            end
        end
    end

    initial begin : main
        int w;
        int cur;
        // {cycle after enable, expected {clk_pdm, stb_left, stb_right, stb_pcm}}
        vecs = '{'{0, 4'b0000}, '{8, 4'b0000}, '{9, 4'b0100}, '{10, 4'b1000},
                 '{11, 4'b1000}, '{18, 4'b1000}, '{19, 4'b1010}, '{20, 4'b0000},
                 '{29, 4'b0100}, '{30, 4'b1000}, '{39, 4'b1010}, '{40, 4'b0000}};

        tick(2);
        mon_en = 1'b1;
        check("reset_ctrl", {25'd0, ctrl_vec()}, 32'd0);
        check("reset_data", frm.frame_data, 32'd0);
        check("reset_state", {30'd0, state_dbg}, 32'd0);

        rst_n     = 1'b1;
        enable    = 1'b1;
        pcm_left  = 16'h1234;
        pcm_right = 16'hFEDC;
        tick(1);
        cur = 0;
        for (int i = 0; i < 12; i++) begin
            tick(vecs[i].t - cur);
            cur = vecs[i].t;
            check($sformatf("startup_vec%0d", i), {28'd0, clk_pdm, stb_left, stb_right, stb_pcm},
                  {28'd0, vecs[i].exp});
        end

        // Warmup: WARMUP pulses, spaced one PCM period, no frames, running only after the last.
        wait_pcm("warm_pcm1", w);
        check("first_pcm_at", cur + w, P);
        for (int k = 2; k <= WARMUP; k++) begin
            wait_pcm($sformatf("warm_pcm%0d", k), w);
            check($sformatf("warm_space%0d", k), w, P);
            check($sformatf("warm_novalid%0d", k), {31'd0, frm.frame_valid}, 32'd0);
            check($sformatf("warm_notrun%0d", k), {31'd0, running}, 32'd0);
        end
        tick(1);
        check("running_rise", {31'd0, running}, 32'd1);
        wait_pcm("run_pcm1", w);
        check("run_space1", w, P - 1);
        tick(2);
        check("capture_not_yet", {31'd0, frm.frame_valid}, 32'd0);
        tick(1);
        check("first_frame_valid", {31'd0, frm.frame_valid}, 32'd1);
        check("first_frame_data", frm.frame_data, 32'h1234FEDC);

        // Overrun: hold frame_ready low for further periods.
        pcm_left  = 16'h1111;
        pcm_right = 16'h2222;
        wait_pcm("ovr_pcm2", w);
        check("ovr_space2", w, P - 3);
        tick(3);
        check("second_head", frm.frame_data, 32'h1234FEDC);
        check("second_no_ovr", {31'd0, overrun}, 32'd0);
        pcm_left  = 16'h3333;
        pcm_right = 16'h4444;
        wait_pcm("ovr_pcm3", w);
        tick(3);
        check("overrun_set", {31'd0, overrun}, 32'd1);
        check("overrun_head_hold", frm.frame_data, 32'h1234FEDC);
        clr_overrun = 1'b1;
        tick(1);
        clr_overrun = 1'b0;
        check("overrun_clr", {31'd0, overrun}, 32'd0);

        // Pop in the exact capture cycle of a full buffer.
        pcm_left  = 16'h5555;
        pcm_right = 16'h6666;
        wait_pcm("full_pcm", w);
        tick(2);
        frm.frame_ready = 1'b1;
        tick(1);
        frm.frame_ready = 1'b0;
        check("full_pushpop_ovr", {31'd0, overrun}, 32'd0);
        check("full_pushpop_head", frm.frame_data, 32'h11112222);
        frm.frame_ready = 1'b1;
        tick(1);
        check("full_pushpop_tail", frm.frame_data, 32'h55556666);
        tick(1);
        frm.frame_ready = 1'b0;
        check("drained", {31'd0, frm.frame_valid}, 32'd0);

        // Randomized traffic in chunks of differing consumer behaviour.
        for (int c = 0; c < 8; c++) begin
            int mode;
            mode = $urandom_range(0, 2);
            for (int i = 0; i < 400; i++) begin
                pcm_left        = 16'($urandom);
                pcm_right       = 16'($urandom);
                clr_overrun     = ($urandom_range(0, 31) == 0);
                frm.frame_ready = (mode == 0) ? 1'b0 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                tick(1);
            end
        end
        clr_overrun     = 1'b0;
        frm.frame_ready = 1'b0;

        // Disable one cycle after stb_pcm with a non-empty buffer and a capture pending.
        wait_pcm("drop_pcmA", w);
        wait_pcm("drop_pcmB", w);
        tick(1);
        check("pre_drop_valid", {31'd0, frm.frame_valid}, 32'd1);
        enable = 1'b0;
        tick(1);
        check("drop_ctrl", {26'd0, clk_pdm, stb_left, stb_right, stb_pcm, running, frm.frame_valid},
              32'd0);
        check("drop_data", frm.frame_data, 32'd0);
        tick(4);
        check("drop_no_late_push", {31'd0, frm.frame_valid}, 32'd0);

        // Re-enable: WARMUP periods discarded again.
        enable    = 1'b1;
        pcm_left  = 16'hAAAA;
        pcm_right = 16'h5555;
        tick(1);
        for (int k = 1; k <= WARMUP + 1; k++) begin
            wait_pcm($sformatf("re_pcm%0d", k), w);
            check($sformatf("re_space%0d", k), w, P);
            check($sformatf("re_novalid%0d", k), {31'd0, frm.frame_valid}, 32'd0);
        end
        tick(3);
        check("re_first_valid", {31'd0, frm.frame_valid}, 32'd1);
        check("re_first_data", frm.frame_data, 32'hAAAA5555);

        // Force an overrun, drain to half full, then reset during RUN.
        wait_pcm("re_pcm18", w);
        wait_pcm("re_pcm19", w);
        tick(3);
        check("re_overrun", {31'd0, overrun}, 32'd1);
        frm.frame_ready = 1'b1;
        tick(1);
        frm.frame_ready = 1'b0;
        check("half_full", {31'd0, frm.frame_valid}, 32'd1);
        rst_n = 1'b0;
        tick(1);
        check("rst_run_ctrl", {25'd0, ctrl_vec()}, 32'd0);
        check("rst_run_data", frm.frame_data, 32'd0);
        enable = 1'b0;
        rst_n  = 1'b1;
        tick(3);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
